// File: rtl/fifo_pkt_reader_if.sv
// Bundles the FIFO read port and the outbound valid/ready stream of the packet reader.
// master = packet reader side, slave = FIFO + stream sink side.
interface fifo_pkt_reader_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int FIFO_SIZE_WIDTH = 10
);
    logic [DATA_WIDTH-1:0]    fifo_rd_data;
    logic                     fifo_rd_rdy;
    logic [FIFO_SIZE_WIDTH:0] fifo_size;
    logic                     fifo_rd_pop;

    logic [DATA_WIDTH-1:0]    m_tdata;
    logic                     m_tvalid;
    logic                     m_tlast;
    logic                     m_tready;

    modport master (
        input  fifo_rd_data, fifo_rd_rdy, fifo_size, m_tready,
        output fifo_rd_pop, m_tdata, m_tvalid, m_tlast
    );

    modport slave (
        output fifo_rd_data, fifo_rd_rdy, fifo_size, m_tready,
        input  fifo_rd_pop, m_tdata, m_tvalid, m_tlast
    );
endinterface

// File: rtl/fifo_pkt_reader.sv
// Pops sample-FIFO words and frames them as header + payload [+ checksum] packets on a stream.
// Optional trailer checksum beat enabled by defining FIFO_PKT_READER_CHECKSUM_EN.
module fifo_pkt_reader #(
    parameter int          DATA_WIDTH      = 32,
    parameter int          FIFO_SIZE       = 1024,
    parameter int          FIFO_SIZE_WIDTH = $clog2(FIFO_SIZE),
    parameter int          PKT_LEN         = 64,
    parameter logic [15:0] SYNC_WORD       = 16'hA5A5
) (
    input  logic                clk,
    input  logic                rstn,
    fifo_pkt_reader_if.master   bus,
    input  logic                enable,
    input  logic                flush_req,
    output logic [7:0]          seq_num,
    output logic                busy,
    output logic                event_starve
);
    localparam int SW = FIFO_SIZE_WIDTH + 1;
    localparam logic [SW-1:0] PKT_LEN_F = SW'(PKT_LEN);
    localparam logic [7:0]    PKT_LEN_B = 8'(PKT_LEN);

    typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_TRAILER} state_t;

    state_t                state_q, state_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            beat_q, beat_d;
    logic [7:0]            seq_q, seq_d;
    logic                  flush_pend_q, flush_pend_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
`ifdef FIFO_PKT_READER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
`endif

    logic                  load;
    logic                  full_ready;
    logic                  flush_ready;
    logic                  start;
    logic                  pay_load;
    logic                  last_pay;
    logic [DATA_WIDTH-1:0] header_word;

    // A beat slot is open when the output register is empty or being drained this cycle.
    assign load        = !tvalid_q || bus.m_tready;
    assign full_ready  = enable && (bus.fifo_size >= PKT_LEN_F);
    assign flush_ready = flush_pend_q && (bus.fifo_size != '0);
    assign start       = (state_q == S_IDLE) && (full_ready || flush_ready);
    assign pay_load    = (state_q == S_PAYLOAD) && load && bus.fifo_rd_rdy;
    assign last_pay    = pay_load && (beat_q == len_q - 8'd1);

    always_comb begin
        header_word       = '0;
        header_word[31:0] = {SYNC_WORD, seq_q, len_q};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            beat_q       <= '0;
            seq_q        <= '0;
            flush_pend_q <= 1'b0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
`ifdef FIFO_PKT_READER_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            beat_q       <= beat_d;
            seq_q        <= seq_d;
            flush_pend_q <= flush_pend_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
`ifdef FIFO_PKT_READER_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_HEADER;
            S_HEADER:  if (load) state_d = S_PAYLOAD;
`ifdef FIFO_PKT_READER_CHECKSUM_EN
            S_PAYLOAD: if (last_pay) state_d = S_TRAILER;
            S_TRAILER: if (load) state_d = S_IDLE;
`else
            S_PAYLOAD: if (last_pay) state_d = S_IDLE;
`endif
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        len_d        = len_q;
        beat_d       = beat_q;
        seq_d        = seq_q;
        flush_pend_d = flush_pend_q || flush_req;
        tdata_d      = tdata_q;
        tvalid_d     = tvalid_q;
        tlast_d      = tlast_q;
`ifdef FIFO_PKT_READER_CHECKSUM_EN
        sum_d        = sum_q;
`endif
        // An accepted beat empties the register unless a new one replaces it below.
        if (load) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d        = (bus.fifo_size >= PKT_LEN_F) ? PKT_LEN_B : 8'(bus.fifo_size);
                    beat_d       = '0;
                    flush_pend_d = 1'b0;
                end else if (bus.fifo_size == '0) begin
                    flush_pend_d = 1'b0;
                end
            end
            S_HEADER: begin
                if (load) begin
                    tdata_d  = header_word;
                    tvalid_d = 1'b1;
`ifdef FIFO_PKT_READER_CHECKSUM_EN
                    sum_d    = '0;
`endif
                end
            end
            S_PAYLOAD: begin
                if (pay_load) begin
                    tdata_d  = bus.fifo_rd_data;
                    tvalid_d = 1'b1;
                    beat_d   = beat_q + 8'd1;
`ifdef FIFO_PKT_READER_CHECKSUM_EN
                    sum_d    = sum_q + bus.fifo_rd_data;
`else
                    tlast_d  = last_pay;
                    if (last_pay) seq_d = seq_q + 8'd1;
`endif
                end
            end
`ifdef FIFO_PKT_READER_CHECKSUM_EN
            S_TRAILER: begin
                if (load) begin
                    tdata_d  = sum_q;
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b1;
                    seq_d    = seq_q + 8'd1;
                end
            end
`endif
            default: ;
        endcase
    end

    assign bus.fifo_rd_pop = pay_load;
    assign event_starve    = (state_q == S_PAYLOAD) && load && !bus.fifo_rd_rdy;
    assign bus.m_tdata     = tdata_q;
    assign bus.m_tvalid    = tvalid_q;
    assign bus.m_tlast     = tlast_q;
    assign seq_num         = seq_q;
    assign busy            = (state_q != S_IDLE);
endmodule
